// File: rtl/dmem_responder.sv
// dmem_responder: shared 16-bit data memory serving NCORES cores.
// Round-robin arbitration, one access in flight (IDLE -> ACCESS -> RESP),
// and a one-cycle per-core ack that marks each completed access.
// Optional build macro DMEM_CONTENTION_CNT_EN adds contention_cnt, a
// saturating count of grants made while two or more cores were requesting.

// Per-core read data register. It loads only when a read for this core
// completes, so the value holds across writes and other cores' traffic.
module dmem_rdata_lane (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ld,
  input  logic [15:0] d,
  output logic [15:0] q
);
  // capture read data on a completed read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (ld)   q <= d;
  end
endmodule

module dmem_responder #(
  parameter int NCORES = 4,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NCORES-1:0][15:0] ar_in,
  input  logic [NCORES-1:0][15:0] dmem_wdata,
  input  logic [NCORES-1:0]       read_MD,
  input  logic [NCORES-1:0]       write_MD,
  output logic [NCORES-1:0][15:0] dmem_rdata,
  output logic [NCORES-1:0]       ack,
  output logic                   busy,
  output logic                   addr_err
`ifdef DMEM_CONTENTION_CNT_EN
  ,
  output logic [15:0]            contention_cnt
`endif
);
  localparam int GW = (NCORES > 1) ? $clog2(NCORES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        state;
  logic [GW-1:0]     ptr;
  logic [GW-1:0]     gnt_q;
  logic [GW-1:0]     gnt_nxt;
  logic              gnt_vld;
  logic [15:0]       addr_q;
  logic [15:0]       wdata_q;
  logic              wr_q;
  logic [NCORES-1:0] req;
  logic              in_range;
  logic [AW-1:0]     idx_q;
  logic [15:0]       rd_val;
  logic [NCORES-1:0] rd_ld;

  logic [15:0] mem [DEPTH];

  // Both strobes high counts as a write, so the write strobe alone picks the op.
  assign req      = read_MD | write_MD;
  assign busy     = (state != S_IDLE);
  // Range check uses the full 16-bit address; only the low AW bits index.
  assign in_range = ({16'd0, addr_q} < DEPTH);
  assign idx_q    = addr_q[AW-1:0];
  assign rd_val   = in_range ? mem[idx_q] : 16'h0000;

  // round-robin pick: first requester strictly after the last-served core
  always_comb begin
    logic [GW-1:0] cand;
    gnt_vld = 1'b0;
    gnt_nxt = '0;
    cand    = '0;
    for (int i = 1; i <= NCORES; i++) begin
      cand = GW'((int'(ptr) + i) % NCORES);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_nxt = cand;
      end
    end
  end

  // one-hot load strobe for the read data lanes
  always_comb begin
    rd_ld = '0;
    if (state == S_ACCESS && !wr_q) rd_ld[gnt_q] = 1'b1;
  end

  // array write; reset_n gates it so a write caught by reset is dropped
  always_ff @(posedge clk) begin
    if (reset_n && state == S_ACCESS && wr_q && in_range) mem[idx_q] <= wdata_q;
  end

  // arbitration FSM, request latch, ack pulse and sticky address error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      ptr      <= GW'(NCORES - 1);
      gnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      ack      <= '0;
      addr_err <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        S_IDLE: begin
          if (gnt_vld) begin
            gnt_q   <= gnt_nxt;
            addr_q  <= ar_in[gnt_nxt];
            wdata_q <= dmem_wdata[gnt_nxt];
            wr_q    <= write_MD[gnt_nxt];
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // ack is registered here so it is high exactly for the RESP cycle
          ack[gnt_q] <= 1'b1;
          if (!in_range) addr_err <= 1'b1;
          state <= S_RESP;
        end
        S_RESP: begin
          ptr   <= gnt_q;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NCORES; k++) begin : g_lane
    dmem_rdata_lane u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .ld      (rd_ld[k]),
      .d       (rd_val),
      .q       (dmem_rdata[k])
    );
  end

`ifdef DMEM_CONTENTION_CNT_EN
  // count contended grants, saturating
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) contention_cnt <= '0;
    else if (state == S_IDLE && gnt_vld && $countones(req) > 1 &&
             contention_cnt != 16'hFFFF)
      contention_cnt <= contention_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed test-plan steps followed by random
// request batches, checked against a behavioural memory/arbiter model.
module tb_dmem_responder;
  localparam int NC    = 4;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NC-1:0][15:0] ar_in;
  logic [NC-1:0][15:0] dmem_wdata;
  logic [NC-1:0][15:0] dmem_rdata;
  logic [NC-1:0]       read_MD;
  logic [NC-1:0]       write_MD;
  logic [NC-1:0]       ack;
  logic                busy;
  logic                addr_err;
`ifdef DMEM_CONTENTION_CNT_EN
  logic [15:0]         contention_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [15:0] m_mem   [DEPTH];
  logic [15:0] m_rdata [NC];
  logic        m_err;
  int          m_ptr;
  int          m_cnt;

  // per-core request staging for a batch
  logic [15:0] b_addr [NC];
  logic [15:0] b_wd   [NC];
  logic        b_rd   [NC];
  logic        b_wr   [NC];

  dmem_responder #(.NCORES(NC), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ar_in      (ar_in),
    .dmem_wdata (dmem_wdata),
    .read_MD    (read_MD),
    .write_MD   (write_MD),
    .dmem_rdata (dmem_rdata),
    .ack        (ack),
    .busy       (busy),
`ifdef DMEM_CONTENTION_CNT_EN
    .contention_cnt (contention_cnt),
`endif
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_err = 1'b0;
    m_ptr = NC - 1;
    m_cnt = 0;
    for (int i = 0; i < NC; i++) m_rdata[i] = 16'h0;
  endtask

  task automatic stage(input int k, input logic [15:0] a, input logic [15:0] wd,
                       input logic rd, input logic wr);
    b_addr[k] = a; b_wd[k] = wd; b_rd[k] = rd; b_wr[k] = wr;
  endtask

  // Raise all staged requests in mask at once (called just after a rising
  // edge with the DUT idle); each core drops its request on the edge that
  // ends its ack. Grants go round-robin after the model pointer, 3 cycles apart.
  task automatic run_batch(input logic [NC-1:0] mask);
    int order[$];
    int n;
    int k;
    logic [NC-1:0] exp_ack;
    logic [15:0] a;
    k = 0;
    for (int j = 1; j <= NC; j++) begin
      k = (m_ptr + j) % NC;
      if (mask[k]) order.push_back(k);
    end
    n = order.size();
    for (int i = 0; i < NC; i++) if (mask[i]) begin
      ar_in[i] = b_addr[i]; dmem_wdata[i] = b_wd[i];
      read_MD[i] = b_rd[i]; write_MD[i] = b_wr[i];
    end
    for (int c = 0; c < 3 * n; c++) begin
      @(negedge clk);
      exp_ack = '0;
      if (c % 3 == 2) begin
        k = order[c / 3];
        exp_ack[k] = 1'b1;
        a = b_addr[k];
        if (a >= DEPTH) m_err = 1'b1;
        if (b_wr[k]) begin
          if (a < DEPTH) m_mem[a[AW-1:0]] = b_wd[k];
        end else begin
          m_rdata[k] = (a < DEPTH) ? m_mem[a[AW-1:0]] : 16'h0000;
        end
        chk($sformatf("rdata[%0d]", k), dmem_rdata[k], m_rdata[k]);
        chk("addr_err", addr_err, m_err);
      end
      chk($sformatf("ack c=%0d", c), ack, exp_ack);
      chk($sformatf("busy c=%0d", c), busy, (c % 3) != 0);
      @(posedge clk); #1;
      if (c % 3 == 2) begin
        read_MD[k] = 1'b0; write_MD[k] = 1'b0;
        m_ptr = k;
      end
    end
    if (n > 1) m_cnt = (m_cnt + n - 1 > 65535) ? 65535 : m_cnt + n - 1;
`ifdef DMEM_CONTENTION_CNT_EN
    chk("contention_cnt", contention_cnt, m_cnt);
`endif
  endtask

  task automatic one(input int k, input logic [15:0] a, input logic [15:0] wd,
                     input logic rd, input logic wr);
    logic [NC-1:0] m;
    m = '0; m[k] = 1'b1;
    stage(k, a, wd, rd, wr);
    run_batch(m);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ack"}, ack, '0);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " addr_err"}, addr_err, 1'b0);
    for (int i = 0; i < NC; i++) chk($sformatf("%s rdata[%0d]", tag, i), dmem_rdata[i], 16'h0);
`ifdef DMEM_CONTENTION_CNT_EN
    chk({tag, " contention_cnt"}, contention_cnt, 16'h0);
`endif
  endtask

  initial begin
    logic [NC-1:0] mask;
    int r;
    ar_in = '0; dmem_wdata = '0; read_MD = '0; write_MD = '0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset_n = 1'b1;

    // core 0 write then read
    one(0, 16'd5, 16'hABCD, 1'b0, 1'b1);
    one(0, 16'd5, 16'h0000, 1'b1, 1'b0);

    // all cores read address 5 together
    for (int i = 0; i < NC; i++) stage(i, 16'd5, 16'h0, 1'b1, 1'b0);
    run_batch('1);

    // last in-range address, then first out-of-range
    one(2, 16'd1023, 16'h1234, 1'b0, 1'b1);
    one(2, 16'd1024, 16'h1234, 1'b0, 1'b1);
    one(2, 16'd1024, 16'h0000, 1'b1, 1'b0);
    one(2, 16'd1023, 16'h0000, 1'b1, 1'b0);

    // read+write together acts as a write and leaves rdata alone
    one(1, 16'd7, 16'h0000, 1'b1, 1'b0);
    one(1, 16'd7, 16'h0F0F, 1'b1, 1'b1);
    one(3, 16'd7, 16'h0000, 1'b1, 1'b0);

    // reset in the middle of a write
    one(0, 16'd9, 16'h0001, 1'b0, 1'b1);
    ar_in[0] = 16'd9; dmem_wdata[0] = 16'h5555; write_MD[0] = 1'b1;
    @(posedge clk); #1;
    chk("busy in access", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midop");
    @(posedge clk); #1;
    chk("ack under reset", ack, '0);
    write_MD[0] = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();

    // three cores at once right after reset: core 0 first, two contended grants
    for (int i = 0; i < 3; i++) stage(i, 16'd5, 16'h0, 1'b1, 1'b0);
    run_batch(4'b0111);
    one(0, 16'd9, 16'h0000, 1'b1, 1'b0);

    // random phase: prefill a small pool, then random batches
    for (int i = 0; i < 8; i++) one(i % NC, 16'(i), 16'($urandom), 1'b0, 1'b1);
    for (int t = 0; t < 25; t++) begin
      mask = NC'($urandom_range(1, (1 << NC) - 1));
      for (int k = 0; k < NC; k++) begin
        r = $urandom_range(0, 9);
        b_addr[k] = (r < 8) ? 16'(r) : (r == 8) ? 16'd1023 : 16'(1024 + $urandom_range(0, 5000));
        b_wd[k] = 16'($urandom);
        r = $urandom_range(0, 2);
        b_rd[k] = (r != 1);
        b_wr[k] = (r != 0);
      end
      run_batch(mask);
    end

    @(negedge clk);
    for (int i = 0; i < NC; i++) chk($sformatf("final rdata[%0d]", i), dmem_rdata[i], m_rdata[i]);
    chk("final ack", ack, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
